// File: rtl/fifo_gen_pkg.sv
// Shared constants, types and helpers for the fifo_gen family.
package fifo_gen_pkg;

    localparam int unsigned DEF_DEPTH_IDX = 2;
    localparam int unsigned DEF_WIDTH     = 4;
    localparam int unsigned DEF_AE_THRESH = 1;
    localparam int unsigned PTR_W_MAX     = 8;

    // Widest legal pointer; each instance narrows it to DEPTH_IDX bits.
    typedef logic [PTR_W_MAX-1:0] ptr_max_t;

    // Count must represent 0..DEPTH inclusive, hence one bit beyond the pointer.
    function automatic int unsigned count_width(input int unsigned depth_idx);
        return depth_idx + 1;
    endfunction

    function automatic int unsigned def_af_thresh(input int unsigned depth_idx);
        return (1 << depth_idx) - 1;
    endfunction

endpackage

// File: rtl/fifo_gen_thresh_if.sv
// Handshake, data and status bundle between the FIFO and its producer/consumer.
interface fifo_gen_thresh_if
    import fifo_gen_pkg::*;
#(
    parameter int unsigned DEPTH_IDX = DEF_DEPTH_IDX,
    parameter int unsigned WIDTH     = DEF_WIDTH
) ();
    localparam int unsigned COUNT_W = count_width(DEPTH_IDX);

    logic               flush;
    logic               in_val;
    logic               in_rdy;
    logic [WIDTH-1:0]   in_data;
    logic               out_val;
    logic               out_rdy;
    logic [WIDTH-1:0]   out_data;
    logic [COUNT_W-1:0] count;
    logic               almost_full;
    logic               almost_empty;

    modport slave (
        input  flush, in_val, in_data, out_rdy,
        output in_rdy, out_val, out_data, count, almost_full, almost_empty
    );

    modport master (
        output flush, in_val, in_data, out_rdy,
        input  in_rdy, out_val, out_data, count, almost_full, almost_empty
    );
endinterface

// File: rtl/fifo_gen_ram.sv
// WIDTH x 2**DEPTH_IDX register array: one synchronous write port, one combinational read port.
module fifo_gen_ram #(
    parameter int unsigned DEPTH_IDX = 2,
    parameter int unsigned WIDTH     = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [DEPTH_IDX-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [DEPTH_IDX-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);
    localparam int unsigned DEPTH = 1 << DEPTH_IDX;

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_gen_thresh.sv
// FWFT circular FIFO with occupancy count, almost-full/empty flags and synchronous flush.
// Define FIFO_GEN_THRESH_BYPASS_EN for a zero-latency pass-through when empty.
module fifo_gen_thresh
    import fifo_gen_pkg::*;
#(
    parameter int unsigned DEPTH_IDX = DEF_DEPTH_IDX,
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned AF_THRESH = def_af_thresh(DEPTH_IDX),
    parameter int unsigned AE_THRESH = DEF_AE_THRESH
) (
    input  logic             clk,
    input  logic             rst,
    fifo_gen_thresh_if.slave bus
);
    localparam int unsigned DEPTH   = 1 << DEPTH_IDX;
    localparam int unsigned COUNT_W = count_width(DEPTH_IDX);

    typedef logic [DEPTH_IDX-1:0] ptr_t;

    ptr_t               wr_ptr;
    ptr_t               rd_ptr;
    logic [COUNT_W-1:0] count;
    logic [WIDTH-1:0]   rdata;
    logic               bypass;
    logic               in_rdy;
    logic               out_val;
    logic               wr_en;
    logic               rd_en;

`ifdef FIFO_GEN_THRESH_BYPASS_EN
    assign bypass = (count == '0) & bus.in_val & bus.out_rdy & ~bus.flush;
`else
    assign bypass = 1'b0;
`endif

    // Flags come from the registered count only, so out_rdy never reaches in_rdy.
    assign in_rdy  = (count != COUNT_W'(DEPTH)) & ~bus.flush;
    assign out_val = ((count != '0) | bypass) & ~bus.flush;

    // A bypassed entry is consumed in flight and never touches storage.
    assign wr_en = bus.in_val & in_rdy & ~bypass;
    assign rd_en = out_val & bus.out_rdy & ~bypass;

    assign bus.in_rdy       = in_rdy;
    assign bus.out_val      = out_val;
    assign bus.out_data     = bypass ? bus.in_data : rdata;
    assign bus.count        = count;
    assign bus.almost_full  = (count >= COUNT_W'(AF_THRESH));
    assign bus.almost_empty = (count <= COUNT_W'(AE_THRESH));

    fifo_gen_ram #(
        .DEPTH_IDX (DEPTH_IDX),
        .WIDTH     (WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (bus.in_data),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Pointers wrap naturally; full/empty are resolved by count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_t'(wr_ptr + ptr_t'(1));
            if (rd_en) rd_ptr <= ptr_t'(rd_ptr + ptr_t'(1));
            unique case ({wr_en, rd_en})
                2'b10:   count <= COUNT_W'(count + COUNT_W'(1));
                2'b01:   count <= COUNT_W'(count - COUNT_W'(1));
                default: count <= count;
            endcase
        end
    end
endmodule
